hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_hazard_ctrl.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline interlock. Per-register countdown scoreboards for GP
//            and SR registers drive stall, bubble and flush controls.
// Options  : HAZARD_STATS_EN enables the 16-bit hazard-stall cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef HBIT_SRC_GP
`define HBIT_SRC_GP 4
`endif
`ifndef HBIT_TGT_GP
`define HBIT_TGT_GP 4
`endif
`ifndef HBIT_SRC_SR
`define HBIT_SRC_SR 2
`endif
`ifndef HBIT_TGT_SR
`define HBIT_TGT_SR 2
`endif

module hazard_ctrl (
   input  logic                   iw_clk,
   input  logic                   iw_rst,
   input  logic                   iw_id_valid,
   input  logic [`HBIT_SRC_GP:0]  iw_src_gp,
   input  logic [`HBIT_TGT_GP:0]  iw_tgt_gp,
   input  logic                   iw_src_gp_re,
   input  logic                   iw_tgt_gp_re,
   input  logic                   iw_tgt_gp_we,
   input  logic [`HBIT_SRC_SR:0]  iw_src_sr,
   input  logic [`HBIT_TGT_SR:0]  iw_tgt_sr,
   input  logic                   iw_src_sr_re,
   input  logic                   iw_tgt_sr_re,
   input  logic                   iw_tgt_sr_we,
   input  logic [1:0]             iw_id_lat,
   input  logic                   iw_branch_taken,
   input  logic                   iw_mem_busy,
   output logic                   or_issue,
   output logic                   or_stall_ifid,
   output logic                   or_bubble_ex,
   output logic                   or_flush_ifid,
   output logic [15:0]            or_stall_cycles
);

   localparam int c_NUM_GP = 1 << (`HBIT_TGT_GP + 1);
   localparam int c_NUM_SR = 1 << (`HBIT_TGT_SR + 1);

   logic [1:0]          r_cnt_gp [0:c_NUM_GP-1];
   logic [1:0]          r_cnt_sr [0:c_NUM_SR-1];
   logic                w_hazard;
   logic                w_freeze;
   logic                w_hazard_stall;
   logic [c_NUM_GP-1:0] w_ld_gp;
   logic [c_NUM_SR-1:0] w_ld_sr;

   assign w_freeze = iw_mem_busy;

   // Reads are checked against the pre-issue counters, so an instruction that
   // both reads and writes one register waits on the older producer.
   always_comb begin
      w_hazard = iw_id_valid &&
                 ((iw_src_gp_re && (r_cnt_gp[iw_src_gp] != 2'd0)) ||
                  (iw_tgt_gp_re && (r_cnt_gp[iw_tgt_gp] != 2'd0)) ||
                  (iw_src_sr_re && (r_cnt_sr[iw_src_sr] != 2'd0)) ||
                  (iw_tgt_sr_re && (r_cnt_sr[iw_tgt_sr] != 2'd0)));
   end

   always_comb begin
      or_issue       = 1'b0;
      or_stall_ifid  = 1'b0;
      or_bubble_ex   = 1'b0;
      or_flush_ifid  = 1'b0;
      w_hazard_stall = 1'b0;
      if (iw_rst) begin
         or_bubble_ex  = 1'b1;
         or_flush_ifid = 1'b1;
      end else if (w_freeze) begin
         or_stall_ifid = 1'b1;
      end else if (iw_branch_taken) begin
         or_flush_ifid = 1'b1;
         or_bubble_ex  = 1'b1;
      end else if (w_hazard) begin
         or_stall_ifid  = 1'b1;
         or_bubble_ex   = 1'b1;
         w_hazard_stall = 1'b1;
      end else begin
         or_issue     = iw_id_valid;
         or_bubble_ex = !iw_id_valid;
      end
   end

   always_comb begin
      w_ld_gp            = '0;
      w_ld_sr            = '0;
      w_ld_gp[iw_tgt_gp] = or_issue && iw_tgt_gp_we;
      w_ld_sr[iw_tgt_sr] = or_issue && iw_tgt_sr_we;
   end

   // A same-cycle load takes priority over the countdown of that entry.
   always_ff @(posedge iw_clk) begin
      if (iw_rst) begin
         for (int i = 0; i < c_NUM_GP; i++) r_cnt_gp[i] <= 2'd0;
         for (int i = 0; i < c_NUM_SR; i++) r_cnt_sr[i] <= 2'd0;
      end else if (!w_freeze) begin
         for (int i = 0; i < c_NUM_GP; i++) begin
            if (w_ld_gp[i])                 r_cnt_gp[i] <= iw_id_lat;
            else if (r_cnt_gp[i] != 2'd0)   r_cnt_gp[i] <= r_cnt_gp[i] - 2'd1;
         end
         for (int i = 0; i < c_NUM_SR; i++) begin
            if (w_ld_sr[i])                 r_cnt_sr[i] <= iw_id_lat;
            else if (r_cnt_sr[i] != 2'd0)   r_cnt_sr[i] <= r_cnt_sr[i] - 2'd1;
         end
      end
   end

`ifdef HAZARD_STATS_EN
   logic [15:0] r_stall_cycles;

   always_ff @(posedge iw_clk) begin
      if (iw_rst)
         r_stall_cycles <= 16'd0;
      else if (w_hazard_stall && (r_stall_cycles != 16'hFFFF))
         r_stall_cycles <= r_stall_cycles + 16'd1;
   end

   assign or_stall_cycles = r_stall_cycles;
`else
   assign or_stall_cycles = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Directed self-checking bench for hazard_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef HBIT_SRC_GP
`define HBIT_SRC_GP 4
`endif
`ifndef HBIT_TGT_GP
`define HBIT_TGT_GP 4
`endif
`ifndef HBIT_SRC_SR
`define HBIT_SRC_SR 2
`endif
`ifndef HBIT_TGT_SR
`define HBIT_TGT_SR 2
`endif

module tb_hazard_ctrl;

   // {issue, stall_ifid, bubble_ex, flush_ifid}
   localparam logic [3:0] c_ISSUE  = 4'b1000;
   localparam logic [3:0] c_STALL  = 4'b0110;
   localparam logic [3:0] c_FREEZE = 4'b0100;
   localparam logic [3:0] c_FLUSH  = 4'b0011;
   localparam logic [3:0] c_RESET  = 4'b0011;
   localparam logic [3:0] c_EMPTY  = 4'b0010;
`ifdef HAZARD_STATS_EN
   localparam bit c_STATS_ON = 1'b1;
`else
   localparam bit c_STATS_ON = 1'b0;
`endif

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  id_valid;
   logic [`HBIT_SRC_GP:0] src_gp;
   logic [`HBIT_TGT_GP:0] tgt_gp;
   logic                  src_gp_re, tgt_gp_re, tgt_gp_we;
   logic [`HBIT_SRC_SR:0] src_sr;
   logic [`HBIT_TGT_SR:0] tgt_sr;
   logic                  src_sr_re, tgt_sr_re, tgt_sr_we;
   logic [1:0]            id_lat;
   logic                  branch_taken, mem_busy;
   logic                  issue, stall_ifid, bubble_ex, flush_ifid;
   logic [15:0]           stall_cycles;
   logic [3:0]            outs;

   int checks = 0;
   int errors = 0;

   assign outs = {issue, stall_ifid, bubble_ex, flush_ifid};

   always #5 clk = ~clk;

   hazard_ctrl dut (
      .iw_clk          (clk),
      .iw_rst          (rst),
      .iw_id_valid     (id_valid),
      .iw_src_gp       (src_gp),
      .iw_tgt_gp       (tgt_gp),
      .iw_src_gp_re    (src_gp_re),
      .iw_tgt_gp_re    (tgt_gp_re),
      .iw_tgt_gp_we    (tgt_gp_we),
      .iw_src_sr       (src_sr),
      .iw_tgt_sr       (tgt_sr),
      .iw_src_sr_re    (src_sr_re),
      .iw_tgt_sr_re    (tgt_sr_re),
      .iw_tgt_sr_we    (tgt_sr_we),
      .iw_id_lat       (id_lat),
      .iw_branch_taken (branch_taken),
      .iw_mem_busy     (mem_busy),
      .or_issue        (issue),
      .or_stall_ifid   (stall_ifid),
      .or_bubble_ex    (bubble_ex),
      .or_flush_ifid   (flush_ifid),
      .or_stall_cycles (stall_cycles)
   );

   // Inputs change 1 ns after the rising edge; outputs are sampled on the
   // falling edge of the same cycle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      id_valid = 1'b0; src_gp = '0; tgt_gp = '0;
      src_gp_re = 1'b0; tgt_gp_re = 1'b0; tgt_gp_we = 1'b0;
      src_sr = '0; tgt_sr = '0;
      src_sr_re = 1'b0; tgt_sr_re = 1'b0; tgt_sr_we = 1'b0;
      id_lat = 2'd0; branch_taken = 1'b0; mem_busy = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic gp_write(input logic [`HBIT_TGT_GP:0] r, input logic [1:0] lat);
      clear_inputs();
      id_valid = 1'b1; tgt_gp = r; tgt_gp_we = 1'b1; id_lat = lat;
   endtask

   task automatic gp_read(input logic [`HBIT_SRC_GP:0] r);
      clear_inputs();
      id_valid = 1'b1; src_gp = r; src_gp_re = 1'b1;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      id_valid = 1'b1;
      tick();
      @(negedge clk);
      checks++;
      if (outs !== c_RESET) begin
         errors++;
         $display("FAIL reset_outs: got %b expected %b", outs, c_RESET);
      end
      checks++;
      if (stall_cycles !== 16'd0) begin
         errors++;
         $display("FAIL reset_stats: got %0d expected 0", stall_cycles);
      end
      tick();
      rst = 1'b0;
   endtask

   task automatic test_load_use();
      do_reset();
      gp_write(3, 2'd2);
      @(negedge clk);
      checks++;
      if (outs !== c_ISSUE) begin
         errors++;
         $display("FAIL ld_use_producer: got %b expected %b", outs, c_ISSUE);
      end
      tick();
      gp_read(3);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (outs !== c_STALL) begin
            errors++;
            $display("FAIL ld_use_stall%0d: got %b expected %b", i, outs, c_STALL);
         end
         tick();
      end
      @(negedge clk);
      checks++;
      if (outs !== c_ISSUE) begin
         errors++;
         $display("FAIL ld_use_issue: got %b expected %b", outs, c_ISSUE);
      end
      checks++;
      if (stall_cycles !== (c_STATS_ON ? 16'd2 : 16'd0)) begin
         errors++;
         $display("FAIL ld_use_stats: got %0d expected %0d", stall_cycles, c_STATS_ON ? 2 : 0);
      end
      tick();
   endtask

   task automatic test_alu_forward();
      do_reset();
      gp_write(5, 2'd0);
      @(negedge clk);
      checks++;
      if (outs !== c_ISSUE) begin
         errors++;
         $display("FAIL alu_producer: got %b expected %b", outs, c_ISSUE);
      end
      tick();
      gp_read(5);
      @(negedge clk);
      checks++;
      if (outs !== c_ISSUE) begin
         errors++;
         $display("FAIL alu_reader: got %b expected %b", outs, c_ISSUE);
      end
      tick();
   endtask

   task automatic test_freeze();
      do_reset();
      gp_write(3, 2'd2);
      tick();
      gp_read(3);
      mem_busy = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (outs !== c_FREEZE) begin
            errors++;
            $display("FAIL freeze_outs%0d: got %b expected %b", i, outs, c_FREEZE);
         end
         tick();
      end
      mem_busy = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (outs !== c_STALL) begin
            errors++;
            $display("FAIL freeze_then_stall%0d: got %b expected %b", i, outs, c_STALL);
         end
         tick();
      end
      @(negedge clk);
      checks++;
      if (outs !== c_ISSUE) begin
         errors++;
         $display("FAIL freeze_issue: got %b expected %b", outs, c_ISSUE);
      end
      checks++;
      if (stall_cycles !== (c_STATS_ON ? 16'd2 : 16'd0)) begin
         errors++;
         $display("FAIL freeze_stats: got %0d expected %0d", stall_cycles, c_STATS_ON ? 2 : 0);
      end
      tick();
   endtask

   task automatic test_branch_over_hazard();
      do_reset();
      gp_write(3, 2'd2);
      tick();
      gp_read(3);
      branch_taken = 1'b1;
      @(negedge clk);
      checks++;
      if (outs !== c_FLUSH) begin
         errors++;
         $display("FAIL branch_flush: got %b expected %b", outs, c_FLUSH);
      end
      tick();
      // The branch cycle still counts down, leaving one hazard cycle.
      branch_taken = 1'b0;
      @(negedge clk);
      checks++;
      if (outs !== c_STALL) begin
         errors++;
         $display("FAIL branch_then_stall: got %b expected %b", outs, c_STALL);
      end
      tick();
      @(negedge clk);
      checks++;
      if (outs !== c_ISSUE) begin
         errors++;
         $display("FAIL branch_then_issue: got %b expected %b", outs, c_ISSUE);
      end
      checks++;
      if (stall_cycles !== (c_STATS_ON ? 16'd1 : 16'd0)) begin
         errors++;
         $display("FAIL branch_stats: got %0d expected %0d", stall_cycles, c_STATS_ON ? 1 : 0);
      end
      tick();
   endtask

   task automatic test_sr_independent();
      do_reset();
      clear_inputs();
      id_valid = 1'b1; tgt_sr = 1; tgt_sr_we = 1'b1; id_lat = 2'd1;
      tick();
      gp_read(1);
      @(negedge clk);
      checks++;
      if (outs !== c_ISSUE) begin
         errors++;
         $display("FAIL sr_vs_gp_index: got %b expected %b", outs, c_ISSUE);
      end
      do_reset();
      clear_inputs();
      id_valid = 1'b1; tgt_sr = 1; tgt_sr_we = 1'b1; id_lat = 2'd1;
      tick();
      clear_inputs();
      id_valid = 1'b1; src_sr = 1; src_sr_re = 1'b1;
      @(negedge clk);
      checks++;
      if (outs !== c_STALL) begin
         errors++;
         $display("FAIL sr_reader_stall: got %b expected %b", outs, c_STALL);
      end
      tick();
      @(negedge clk);
      checks++;
      if (outs !== c_ISSUE) begin
         errors++;
         $display("FAIL sr_reader_issue: got %b expected %b", outs, c_ISSUE);
      end
      tick();
   endtask

   task automatic test_self_rw();
      do_reset();
      gp_write(7, 2'd2);
      tick();
      // Reads r7 as target operand and rewrites r7 as an ALU result.
      clear_inputs();
      id_valid = 1'b1; tgt_gp = 7; tgt_gp_re = 1'b1; tgt_gp_we = 1'b1; id_lat = 2'd0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (outs !== c_STALL) begin
            errors++;
            $display("FAIL self_rw_stall%0d: got %b expected %b", i, outs, c_STALL);
         end
         tick();
      end
      @(negedge clk);
      checks++;
      if (outs !== c_ISSUE) begin
         errors++;
         $display("FAIL self_rw_issue: got %b expected %b", outs, c_ISSUE);
      end
      tick();
      gp_read(7);
      @(negedge clk);
      checks++;
      if (outs !== c_ISSUE) begin
         errors++;
         $display("FAIL self_rw_follow: got %b expected %b", outs, c_ISSUE);
      end
      tick();
   endtask

   task automatic test_invalid_id();
      do_reset();
      gp_write(3, 2'd2);
      tick();
      gp_read(3);
      id_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (outs !== c_EMPTY) begin
         errors++;
         $display("FAIL invalid_id: got %b expected %b", outs, c_EMPTY);
      end
      tick();
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      gp_write(3, 2'd2);
      tick();
      gp_read(3);
      @(negedge clk);
      checks++;
      if (outs !== c_STALL) begin
         errors++;
         $display("FAIL rst_mid_pre: got %b expected %b", outs, c_STALL);
      end
      tick();
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (outs !== c_RESET) begin
         errors++;
         $display("FAIL rst_mid_outs: got %b expected %b", outs, c_RESET);
      end
      tick();
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (outs !== c_ISSUE) begin
         errors++;
         $display("FAIL rst_mid_after: got %b expected %b", outs, c_ISSUE);
      end
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      clear_inputs();
      rst = 1'b1;
      test_reset();
      test_load_use();
      test_alu_forward();
      test_freeze();
      test_branch_over_hazard();
      test_sr_independent();
      test_self_rw();
      test_invalid_id();
      test_reset_mid_stall();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
